// File: rtl/gmem_port_arbiter.sv
// gmem_port_arbiter: round-robin arbiter serialising channel reads/writes onto one single-ported array.
// Optional request-protocol checker enabled by defining GMEM_PROTOCOL_CHECK_EN.
module gmem_port_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY = 2,
  parameter int WRITE_ENABLE = 1,
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   host_write_valid,
  input  logic [ADDR_BITS-1:0]                   host_write_address,
  input  logic [DATA_BITS-1:0]                   host_write_data,
  output logic                                   protocol_error,
  output logic [CW-1:0]                          error_channel
);
  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;
  state_t                state_q [NUM_CHANNELS];
  state_t                state_d [NUM_CHANNELS];
  logic [3:0]            cnt_q   [NUM_CHANNELS];
  logic [3:0]            cnt_d   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]  resp_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]  resp_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] op_q, op_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [DATA_BITS-1:0]  mem [2**ADDR_BITS];
  logic [NUM_CHANNELS-1:0] elig;
  logic                  gnt, gnt_wr;
  logic [CW-1:0]         gnt_idx;
  logic [ADDR_BITS-1:0]  gnt_addr;
  logic [DATA_BITS-1:0]  rd_word;
  always_comb begin
    logic [CW-1:0] cand;
    cand = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      elig[i] = state_q[i] == IDLE && (mem_read_valid[i] || (WRITE_ENABLE != 0 && mem_write_valid[i]));
    gnt = 1'b0;
    gnt_idx = '0;
    // descending scan so the candidate closest to the pointer wins
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      cand = CW'((int'(ptr_q) + k) % NUM_CHANNELS);
      if (elig[cand]) begin
        gnt = !reset && !host_write_valid;
        gnt_idx = cand;
      end
    end
    gnt_wr = !mem_read_valid[gnt_idx];
    gnt_addr = gnt_wr ? mem_write_address[gnt_idx] : mem_read_address[gnt_idx];
    rd_word = mem[gnt_addr];
    ptr_d = gnt ? (gnt_idx == CW'(NUM_CHANNELS - 1) ? '0 : gnt_idx + CW'(1)) : ptr_q;
  end
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i] = cnt_q[i];
      op_d[i] = op_q[i];
      resp_d[i] = resp_q[i];
      if (state_q[i] == IDLE && gnt && gnt_idx == CW'(i)) begin
        state_d[i] = LATENCY == 1 ? RESPOND : BUSY;
        cnt_d[i] = 4'(LATENCY - 1);
        op_d[i] = gnt_wr;
        resp_d[i] = gnt_wr ? resp_q[i] : rd_word;
      end else if (state_q[i] == BUSY) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
        state_d[i] = cnt_q[i] == 4'd1 ? RESPOND : BUSY;
      end else if (state_q[i] == RESPOND) begin
        state_d[i] = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      op_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i] <= '0;
        resp_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      op_q <= op_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
        resp_q[i] <= resp_d[i];
      end
    end
  end
  // array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (host_write_valid) mem[host_write_address] <= host_write_data;
    else if (gnt && gnt_wr) mem[gnt_addr] <= mem_write_data[gnt_idx];
  end
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      mem_read_ready[i] = state_q[i] == RESPOND && !op_q[i];
      mem_write_ready[i] = state_q[i] == RESPOND && op_q[i];
      mem_read_data[i] = (state_q[i] == RESPOND && !op_q[i]) ? resp_q[i] : '0;
    end
  end
`ifdef GMEM_PROTOCOL_CHECK_EN
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] viol;
  logic                 err_q, err_d;
  logic [CW-1:0]        ech_q, ech_d;
  always_comb begin
    err_d = err_q;
    ech_d = ech_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      addr_d[i] = (gnt && gnt_idx == CW'(i)) ? gnt_addr : addr_q[i];
      wdata_d[i] = (gnt && gnt_idx == CW'(i)) ? mem_write_data[i] : wdata_q[i];
      // dropping valid during RESPOND is the normal handshake, changing the request is not
      viol[i] = (state_q[i] == BUSY && !(op_q[i] ? mem_write_valid[i] : mem_read_valid[i]))
             || ((state_q[i] == BUSY || (state_q[i] == RESPOND && (op_q[i] ? mem_write_valid[i] : mem_read_valid[i])))
                 && ((op_q[i] ? mem_write_address[i] : mem_read_address[i]) != addr_q[i]
                     || (op_q[i] && mem_write_data[i] != wdata_q[i])));
    end
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (!err_q && viol[i]) begin
        err_d = 1'b1;
        ech_d = CW'(i);
      end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      addr_q[i] <= addr_d[i];
      wdata_q[i] <= wdata_d[i];
    end
    err_q <= reset ? 1'b0 : err_d;
    ech_q <= reset ? '0 : ech_d;
  end
  assign protocol_error = err_q;
  assign error_channel = ech_q;
`else
  assign protocol_error = 1'b0;
  assign error_channel = '0;
`endif
endmodule

// File: tb/tb_gmem_port_arbiter.sv
// tb_gmem_port_arbiter: vector table, directed multi-cycle sequences and a randomized
// run against a grant-timeline reference model of the arbiter.
module tb_gmem_port_arbiter;
  localparam int N = 4, AW = 8, DW = 16, LAT = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] mem_read_valid = '0, mem_read_ready, mem_write_valid = '0, mem_write_ready;
  logic [N-1:0][AW-1:0] mem_read_address = '0, mem_write_address = '0;
  logic [N-1:0][DW-1:0] mem_read_data, mem_write_data = '0;
  logic host_write_valid = 1'b0;
  logic [AW-1:0] host_write_address = '0;
  logic [DW-1:0] host_write_data = '0;
  logic protocol_error;
  logic [1:0] error_channel;
`ifdef GMEM_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  gmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .host_write_valid(host_write_valid), .host_write_address(host_write_address),
    .host_write_data(host_write_data),
    .protocol_error(protocol_error), .error_channel(error_channel));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int rc[N], wc[N];
  logic [DW-1:0] rdv[N];

  typedef struct {
    int ch;
    bit wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_write_valid = 1'b1;
    host_write_address = a;
    host_write_data = d;
    @(negedge clk);
    host_write_valid = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_rr"}, 32'(mem_read_ready), 0);
    check({name, "_wr"}, 32'(mem_write_ready), 0);
    check({name, "_rd"}, 32'(|mem_read_data), 0);
  endtask

  // single transaction; reports latency in cycles, returned data, and any stray handshake
  task automatic txn(input int ch, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output int lat, output logic [DW-1:0] rd, output bit bad);
    lat = -1; rd = '0; bad = 1'b0;
    if (wr) begin
      mem_write_valid[ch] = 1'b1; mem_write_address[ch] = a; mem_write_data[ch] = d;
    end else begin
      mem_read_valid[ch] = 1'b1; mem_read_address[ch] = a;
    end
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_read_ready[ch] || mem_write_ready[ch]) begin
        lat = c;
        rd = mem_read_data[ch];
        if ((wr ? mem_read_ready[ch] : mem_write_ready[ch])
            || (((mem_read_ready | mem_write_ready) & ~(N'(1) << ch)) != 0)) bad = 1'b1;
        mem_read_valid[ch] = 1'b0; mem_write_valid[ch] = 1'b0;
      end else if ((mem_read_ready | mem_write_ready) != 0 || mem_read_data != '0) bad = 1'b1;
    end
    mem_read_valid[ch] = 1'b0; mem_write_valid[ch] = 1'b0;
    @(negedge clk);
    if ((mem_read_ready | mem_write_ready) != 0 || mem_read_data != '0) bad = 1'b1;
  endtask

  // records first read/write ready cycle per channel, dropping each op's valid on its ready
  task automatic watch(input int host_off);
    for (int i = 0; i < N; i++) begin rc[i] = -1; wc[i] = -1; rdv[i] = '0; end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == host_off) host_write_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (mem_read_ready[i] && rc[i] < 0) begin rc[i] = c; rdv[i] = mem_read_data[i]; mem_read_valid[i] = 1'b0; end
        if (mem_write_ready[i] && wc[i] < 0) begin wc[i] = c; mem_write_valid[i] = 1'b0; end
      end
    end
  endtask

  // randomized run against a timeline model: each request gets a grant cycle from
  // round-robin over pending requesters, and its answer is due LAT cycles later
  task automatic random_run(input int cycles);
    bit act[N], granted[N], opw[N];
    int due[N];
    logic [DW-1:0] mdl[16], resp[N];
    logic [3:0] ra[N];
    logic [DW-1:0] wd[N];
    int ptr = 0;
    for (int a = 0; a < 16; a++) begin
      mdl[a] = DW'($urandom);
      host_wr(AW'(a), mdl[a]);
    end
    for (int i = 0; i < N; i++) begin act[i] = 0; granted[i] = 0; opw[i] = 0; due[i] = -1; resp[i] = '0; ra[i] = '0; wd[i] = '0; end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        check("rnd_rr", 32'(mem_read_ready[i]), 32'(due[i] == c && !opw[i]));
        check("rnd_wr", 32'(mem_write_ready[i]), 32'(due[i] == c && opw[i]));
        check("rnd_data", 32'(mem_read_data[i]), (due[i] == c && !opw[i]) ? 32'(resp[i]) : 0);
      end
      for (int i = 0; i < N; i++) begin
        if (due[i] == c) begin
          act[i] = 0;
          mem_read_valid[i] = 1'b0; mem_write_valid[i] = 1'b0;
        end else if (!act[i] && $urandom_range(2) == 0) begin
          act[i] = 1; granted[i] = 0; due[i] = -1;
          opw[i] = 1'($urandom_range(1));
          ra[i] = 4'($urandom_range(15));
          wd[i] = DW'($urandom);
          if (opw[i]) begin
            mem_write_valid[i] = 1'b1; mem_write_address[i] = AW'(ra[i]); mem_write_data[i] = wd[i];
          end else begin
            mem_read_valid[i] = 1'b1; mem_read_address[i] = AW'(ra[i]);
          end
        end
      end
      host_write_valid = $urandom_range(7) == 0;
      host_write_address = AW'($urandom_range(15));
      host_write_data = DW'($urandom);
      if (host_write_valid) mdl[host_write_address[3:0]] = host_write_data;
      else begin
        for (int k = 0; k < N; k++) begin
          int g;
          g = (ptr + k) % N;
          if (act[g] && !granted[g]) begin
            granted[g] = 1;
            due[g] = c + LAT;
            if (opw[g]) mdl[ra[g]] = wd[g];
            else resp[g] = mdl[ra[g]];
            ptr = (g + 1) % N;
            break;
          end
        end
      end
      @(negedge clk);
    end
    host_write_valid = 1'b0;
    mem_read_valid = '0;
    mem_write_valid = '0;
  endtask

  initial begin
    int lat, stray;
    logic [DW-1:0] rd;
    bit bad;
    tbl[0] = '{0, 1'b0, 8'h10, 16'h0000, 16'h1234};
    tbl[1] = '{1, 1'b1, 8'h20, 16'hBEEF, 16'h0000};
    tbl[2] = '{1, 1'b0, 8'h20, 16'h0000, 16'hBEEF};
    tbl[3] = '{2, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
    tbl[4] = '{3, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
    tbl[5] = '{0, 1'b1, 8'h20, 16'h5A5A, 16'h0000};
    tbl[6] = '{2, 1'b0, 8'h20, 16'h0000, 16'h5A5A};
    tbl[7] = '{3, 1'b0, 8'h00, 16'h0000, 16'h0F0F};

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_quiet("reset");
    check("reset_perr", 32'(protocol_error), 0);
    check("reset_ech", 32'(error_channel), 0);

    host_wr(8'h10, 16'h1234);
    host_wr(8'h00, 16'h0F0F);
    host_wr(8'h30, 16'h3333);
    for (int i = 0; i < N; i++) host_wr(AW'(8'h40 + i), DW'(16'hA000 + i));

    for (int v = 0; v < 8; v++) begin
      txn(tbl[v].ch, tbl[v].wr, tbl[v].a, tbl[v].d, lat, rd, bad);
      check($sformatf("vec%0d_lat", v), 32'(lat), LAT);
      check($sformatf("vec%0d_data", v), 32'(rd), 32'(tbl[v].exp));
      check($sformatf("vec%0d_clean", v), 32'(bad), 0);
    end

    // all four channels contend straight after reset
    do_reset();
    for (int i = 0; i < N; i++) begin mem_read_valid[i] = 1'b1; mem_read_address[i] = AW'(8'h40 + i); end
    watch(0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rr%0d_cycle", i), 32'(rc[i]), 32'(LAT + i));
      check($sformatf("rr%0d_data", i), 32'(rdv[i]), 32'(16'hA000 + i));
    end

    // host port holds off a pending channel read for three cycles
    host_write_valid = 1'b1; host_write_address = 8'h80; host_write_data = 16'h1111;
    mem_read_valid[2] = 1'b1; mem_read_address[2] = 8'h42;
    watch(3);
    check("host_hold_cycle", 32'(rc[2]), 32'(3 + LAT));
    check("host_hold_data", 32'(rdv[2]), 32'h0000A002);
    txn(1, 1'b0, 8'h80, '0, lat, rd, bad);
    check("host_data", 32'(rd), 32'h1111);

    // read and write both valid on one channel: read first, write after the read completes
    mem_read_valid[1] = 1'b1; mem_read_address[1] = 8'h30;
    mem_write_valid[1] = 1'b1; mem_write_address[1] = 8'h30; mem_write_data[1] = 16'h7777;
    watch(0);
    check("rw_read_cycle", 32'(rc[1]), LAT);
    check("rw_read_data", 32'(rdv[1]), 32'h3333);
    check("rw_write_cycle", 32'(wc[1]), 32'(2 * LAT + 1));
    txn(2, 1'b0, 8'h30, '0, lat, rd, bad);
    check("rw_after", 32'(rd), 32'h7777);

    // reset while a read is in flight drops it
    mem_read_valid[0] = 1'b1; mem_read_address[0] = 8'h40;
    @(negedge clk);
    mem_read_valid[0] = 1'b0;
    do_reset();
    check_quiet("midrst");
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ((mem_read_ready | mem_write_ready) != 0) stray++;
    end
    check("midrst_no_ready", 32'(stray), 0);
    txn(0, 1'b0, 8'h40, '0, lat, rd, bad);
    check("midrst_after_lat", 32'(lat), LAT);
    check("midrst_after_data", 32'(rd), 32'hA000);

    do_reset();
    random_run(400);
    @(negedge clk);
    check("rnd_perr", 32'(protocol_error), 0);

    // ch3 moves its address while BUSY
    do_reset();
    host_wr(8'h41, 16'hA001);
    mem_read_valid[3] = 1'b1; mem_read_address[3] = 8'h41;
    @(negedge clk);
    mem_read_address[3] = 8'h55;
    watch(0);
    check("perr_txn_cycle", 32'(rc[3]), LAT - 1);
    check("perr_txn_data", 32'(rdv[3]), 32'hA001);
    check("perr_flag", 32'(protocol_error), 32'(CHK));
    check("perr_chan", 32'(error_channel), CHK ? 3 : 0);
    repeat (3) @(negedge clk);
    check("perr_sticky", 32'(protocol_error), 32'(CHK));
    do_reset();
    check("perr_cleared", 32'(protocol_error), 0);
    check("perr_chan_cleared", 32'(error_channel), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gmem_port_arbiter.md
# gmem_port_arbiter

Global-memory endpoint for the memory controller's channel interface. It accepts read/write requests from NUM_CHANNELS controller channels and serialises them onto one single-ported internal storage array using round-robin arbitration. Each request is answered with a one-cycle ready pulse, plus data for reads, after a fixed latency. A host preload port lets the testbench or boot logic fill the array.

## Interface
- ADDR_BITS, 8: address width; array depth is 2^ADDR_BITS words.
- DATA_BITS, 16: word width.
- NUM_CHANNELS, 4: number of controller channels served.
- LATENCY, 2: cycles from grant to ready pulse; legal range is 1 to 15.
- WRITE_ENABLE, 1: 0 makes the array read-only to channels.

Ports:
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request, held until ready.
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS  read address per channel.
- mem_read_ready  out  NUM_CHANNELS  one-cycle read completion pulse.
- mem_read_data  out  DATA_BITS x NUM_CHANNELS  read data; valid only while ready is high, 0 otherwise.
- mem_write_valid  in  NUM_CHANNELS  per-channel write request, held until ready.
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS  write address.
- mem_write_data  in  DATA_BITS x NUM_CHANNELS  write data.
- mem_write_ready  out  NUM_CHANNELS  one-cycle write completion pulse.
- host_write_valid  in  1  direct array write; has priority over all channels.
- host_write_address  in  ADDR_BITS  host write address.
- host_write_data  in  DATA_BITS  host write data.
- protocol_error  out  1  sticky flag: a channel violated the request protocol.
- error_channel  out  $clog2(NUM_CHANNELS), minimum 1 bit  index of the first offending channel.

## Operation
- Each channel has its own FSM with states IDLE, BUSY and RESPOND, plus a 4-bit countdown.
- A channel is eligible when it is in IDLE and has read or write valid asserted. Write valid counts only when WRITE_ENABLE=1.
- At most one grant is made per cycle.
  - Grant goes to the first eligible channel at or after the round-robin pointer.
  - The pointer then advances to the granted channel + 1, modulo NUM_CHANNELS.
- If a channel asserts both read and write valid, the read is granted and the write waits.
- At grant, the array is accessed in the same cycle:
  - a write commits data to the array;
  - a read captures the array word into a per-channel response register;
  - the channel stores the operation type and address, and the countdown loads LATENCY-1.
- After grant:
  - countdown == 0 moves the channel to RESPOND;
  - otherwise it moves to BUSY, which decrements the countdown each cycle and moves to RESPOND at 0.
- RESPOND lasts exactly one cycle:
  - the matching ready bit is asserted, and for reads the data is driven;
  - the channel returns to IDLE;
  - the channel is not eligible for a grant during its RESPOND cycle.
- Ordering is global grant order. A read granted after a write to the same address returns the new data.
- host_write_valid writes the array that cycle and suppresses any channel grant for that cycle. The round-robin pointer is unchanged.
- WRITE_ENABLE=0: write valids are ignored, mem_write_ready stays 0, and the requester stalls forever. This is the intended configuration for program memory.

## Timing
- Request valid in cycle T with no contention: grant at the T clock edge, ready high in cycle T+LATENCY.
- With N channels contending: the worst-case wait before grant is N-1 cycles, plus any cycles consumed by host writes.
- Array read data is from before any same-cycle write, because only one access happens per cycle.
- Reset values:
  - all ready outputs, read data and protocol_error are 0;
  - error_channel is 0, all FSMs are IDLE, the pointer is 0;
  - array contents are NOT reset.
- Reset mid-operation: pending transactions are dropped and no ready is issued. Writes already granted stay committed.
- Ready outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro GMEM_PROTOCOL_CHECK_EN.
- Defined: while a channel is in BUSY or RESPOND, the checker watches that channel's request.
  - Violation: the granted op's valid drops, or its address changes (or write data changes, for writes).
  - On the first violation, protocol_error is set and error_channel captures the channel index.
  - Both hold until reset.
  - A drop of valid in the same cycle as the ready pulse is legal.
- Undefined: protocol_error and error_channel are tied to 0; transaction behaviour is identical.

## Test plan
- Host preloads addr 0x10=0x1234; ch0 reads 0x10 at T -> mem_read_ready[0] high only in T+2, data 0x1234, 0 in all other cycles.
- ch1 writes 0x20=0xBEEF at T, ch1 reads 0x20 after ready -> write ready at T+2, read returns 0xBEEF.
- All 4 channels read distinct preloaded addresses in the same cycle after reset -> grants in order 0,1,2,3, readies at T+2..T+5, each carrying correct data.
- host_write_valid held 3 cycles while ch2 read pending -> no grant for those cycles; ch2 ready 2 cycles after host releases.
- Reset asserted while ch0 is BUSY -> no ready ever issued for that request, all outputs 0 next cycle; a new read after reset completes normally.
- With GMEM_PROTOCOL_CHECK_EN, ch3 changes address mid-BUSY -> protocol_error=1, error_channel=3, sticky until reset. Without the macro, both stay 0.
